uart_rx_16x: RTL and testbench

UART receiver that consumes the 16x-oversample clock produced by the UART baud divider (50 MHz / 326, giving 9600 baud × 16). It runs entirely in the clk50 domain and uses the divider output only as a rising-edge-detected sample enable. It recovers 8N1 frames from the rxd pin, LSB first, using majority-vote sampling, and delivers each byte with a single-cycle valid strobe to the downstream command parser.

---
 rtl/uart_rx_16x.sv | 192 +++++++++++++++++++
 tb/tb_uart_rx_16x.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_16x.sv
// 8N1 UART receiver driven by a 16x oversample enable, majority-vote bit recovery.
// Optional even-parity checking is enabled by defining UART_RX_PARITY_EN.
module uart_rx_16x #(
  parameter int DATA_BITS   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk50,
  input  logic                 rst_n,
  input  logic                 tick16,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_frame_err,
`ifdef UART_RX_PARITY_EN
  output logic                 rx_parity_err,
`endif
  output logic                 rx_busy
);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;
`endif

  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

  function automatic logic even_parity_ok(input logic [DATA_BITS-1:0] d, input logic p);
    return ~(^{d, p});
  endfunction

  state_t               state_r, state_n;
  logic [SYNC_STAGES-1:0] sync_r;
  logic                 tick16_d_r;
  logic [3:0]           cnt_r, cnt_n;
  logic [2:0]           bit_idx_r, bit_idx_n;
  logic [DATA_BITS-1:0] shift_r, shift_n;
  logic [2:0]           votes_r, votes_n;
  logic [DATA_BITS-1:0] data_n;
  logic                 valid_n, ferr_n, busy_n;
  logic                 tick_en_s, rxd_s, maj_s, maj_stop_s;
`ifdef UART_RX_PARITY_EN
  logic                 par_r, par_n, perr_n;
`endif

  assign tick_en_s  = tick16 & ~tick16_d_r;
  assign rxd_s      = sync_r[SYNC_STAGES-1];
  assign maj_s      = maj3(votes_r);
  // The stop bit is judged on the cnt = 9 tick itself, so its third vote is the live sample.
  assign maj_stop_s = maj3({rxd_s, votes_r[1:0]});

  // Next-state, counters, sampling and output strobes.
  always_comb begin
    state_n   = state_r;
    cnt_n     = cnt_r;
    bit_idx_n = bit_idx_r;
    shift_n   = shift_r;
    votes_n   = votes_r;
    data_n    = rx_data;
    valid_n   = 1'b0;
    ferr_n    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_n     = par_r;
    perr_n    = 1'b0;
`endif
    if (tick_en_s) begin
      cnt_n = cnt_r + 4'd1;
      case (cnt_r)
        4'd7:    votes_n[0] = rxd_s;
        4'd8:    votes_n[1] = rxd_s;
        4'd9:    votes_n[2] = rxd_s;
        default: votes_n = votes_r;
      endcase
      case (state_r)
        IDLE: begin
          cnt_n = 4'd0;
          if (!rxd_s) state_n = START;
          else        state_n = IDLE;
        end
        START: begin
          if (cnt_r == 4'd15) begin
            if (maj_s) begin
              state_n = IDLE;
            end else begin
              state_n   = DATA;
              bit_idx_n = 3'd0;
            end
          end else begin
            state_n = START;
          end
        end
        DATA: begin
          if (cnt_r == 4'd15) begin
            shift_n = {maj_s, shift_r[DATA_BITS-1:1]};
            if (bit_idx_r == 3'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
              state_n = PARITY;
`else
              state_n = STOP;
`endif
            end else begin
              bit_idx_n = bit_idx_r + 3'd1;
            end
          end else begin
            state_n = DATA;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt_r == 4'd15) begin
            par_n   = maj_s;
            state_n = STOP;
          end else begin
            state_n = PARITY;
          end
        end
`endif
        STOP: begin
          if (cnt_r == 4'd9) begin
            if (maj_stop_s) begin
              state_n = IDLE;
`ifdef UART_RX_PARITY_EN
              if (even_parity_ok(shift_r, par_r)) begin
                data_n  = shift_r;
                valid_n = 1'b1;
              end else begin
                perr_n = 1'b1;
              end
`else
              data_n  = shift_r;
              valid_n = 1'b1;
`endif
            end else begin
              ferr_n  = 1'b1;
              state_n = BRK;
            end
          end else begin
            state_n = STOP;
          end
        end
        BRK: begin
          if (rxd_s) state_n = IDLE;
          else       state_n = BRK;
        end
        default: state_n = IDLE;
      endcase
    end else begin
      state_n = state_r;
    end
    busy_n = (state_n != IDLE);
  end

  // State and output registers; the synchroniser idles high like the line.
  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      sync_r       <= {SYNC_STAGES{1'b1}};
      tick16_d_r   <= 1'b0;
      state_r      <= IDLE;
      cnt_r        <= 4'd0;
      bit_idx_r    <= 3'd0;
      shift_r      <= {DATA_BITS{1'b0}};
      votes_r      <= 3'b000;
      rx_data      <= {DATA_BITS{1'b0}};
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_busy      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_r         <= 1'b0;
      rx_parity_err <= 1'b0;
`endif
    end else begin
      sync_r       <= {sync_r[SYNC_STAGES-2:0], rxd};
      tick16_d_r   <= tick16;
      state_r      <= state_n;
      cnt_r        <= cnt_n;
      bit_idx_r    <= bit_idx_n;
      shift_r      <= shift_n;
      votes_r      <= votes_n;
      rx_data      <= data_n;
      rx_valid     <= valid_n;
      rx_frame_err <= ferr_n;
      rx_busy      <= busy_n;
`ifdef UART_RX_PARITY_EN
      par_r         <= par_n;
      rx_parity_err <= perr_n;
`endif
    end
  end

endmodule

// File: tb/tb_uart_rx_16x.sv
// Directed bench for uart_rx_16x: vector table of frames plus hand-written corner sequences.
// The receiver is rate-independent, so a short tick16 period keeps frames brief.
module tb_uart_rx_16x;

  localparam int TICK_HALF = 4;

  logic       clk50 = 1'b0;
  logic       rst_n;
  logic       tick16;
  logic       rxd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_frame_err;
  logic       rx_busy;
  logic       rx_parity_err;

  int n_checks = 0;
  int n_pass   = 0;
  int n_valid  = 0;
  int n_ferr   = 0;
  int n_perr   = 0;

  uart_rx_16x #(.DATA_BITS(8), .SYNC_STAGES(2)) dut (
    .clk50        (clk50),
    .rst_n        (rst_n),
    .tick16       (tick16),
    .rxd          (rxd),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_frame_err (rx_frame_err),
`ifdef UART_RX_PARITY_EN
    .rx_parity_err(rx_parity_err),
`endif
    .rx_busy      (rx_busy)
  );

`ifndef UART_RX_PARITY_EN
  assign rx_parity_err = 1'b0;
`endif

  always #10 clk50 = ~clk50;

  initial begin
    tick16 = 1'b0;
    forever begin
      repeat (TICK_HALF) @(negedge clk50);
      tick16 = ~tick16;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Pulse monitor: counts strobes and checks width and mutual exclusion.
  initial begin
    logic valid_prev = 1'b0;
    logic ferr_prev  = 1'b0;
    forever begin
      @(negedge clk50);
      if (rx_valid) n_valid++;
      if (rx_frame_err) n_ferr++;
      if (rx_parity_err) n_perr++;
      if (rx_valid || rx_frame_err) check("valid_ferr_exclusive", rx_valid & rx_frame_err, 0);
      if (valid_prev) check("valid_width", rx_valid, 0);
      if (ferr_prev) check("ferr_width", rx_frame_err, 0);
      valid_prev = rx_valid;
      ferr_prev  = rx_frame_err;
    end
  end

  initial begin
    repeat (90000) @(posedge clk50);
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic drive_tick(input logic v);
    rxd = v;
    @(posedge tick16);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_ok, input logic glitch,
                            input logic bad_par);
    logic [10:0] bits;
    int nslots;
    logic v;
`ifdef UART_RX_PARITY_EN
    bits   = {stop_ok, (^d) ^ bad_par, d, 1'b0};
    nslots = 11;
`else
    bits   = {1'b1, stop_ok, d, 1'b0};
    nslots = 10;
`endif
    for (int s = 0; s < nslots; s++) begin
      for (int t = 0; t < 16; t++) begin
        v = bits[s];
        if (glitch && s == 3 && t == 9) v = ~v;
        drive_tick(v);
      end
    end
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop_ok;
    logic       glitch;
    int         exp_valid;
    int         exp_ferr;
    logic [7:0] exp_data;
    logic       exp_busy;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int v0, f0, p0;
    vecs[0] = '{8'h55, 1'b1, 1'b0, 1, 0, 8'h55, 1'b0};
    vecs[1] = '{8'hA5, 1'b1, 1'b0, 1, 0, 8'hA5, 1'b0};
    vecs[2] = '{8'h3C, 1'b1, 1'b0, 1, 0, 8'h3C, 1'b0};
    vecs[3] = '{8'hC3, 1'b1, 1'b1, 1, 0, 8'hC3, 1'b0};
    vecs[4] = '{8'h0F, 1'b0, 1'b0, 0, 1, 8'hC3, 1'b1};

    rst_n = 1'b0;
    rxd   = 1'b1;
    repeat (5) @(negedge clk50);
    check("reset_rx_data", rx_data, 0);
    check("reset_rx_valid", rx_valid, 0);
    check("reset_rx_frame_err", rx_frame_err, 0);
    check("reset_rx_busy", rx_busy, 0);
    rst_n = 1'b1;
    @(posedge tick16);
    repeat (16) drive_tick(1'b1);

    // Frames are sent back to back with no idle gap between them.
    for (int i = 0; i < 5; i++) begin
      v0 = n_valid; f0 = n_ferr;
      send_frame(vecs[i].data, vecs[i].stop_ok, vecs[i].glitch, 1'b0);
      check($sformatf("vec%0d_valid", i), n_valid - v0, vecs[i].exp_valid);
      check($sformatf("vec%0d_ferr", i), n_ferr - f0, vecs[i].exp_ferr);
      check($sformatf("vec%0d_data", i), rx_data, vecs[i].exp_data);
      check($sformatf("vec%0d_busy", i), rx_busy, vecs[i].exp_busy);
    end

    // Break: line held low three frame times after the bad stop bit.
    v0 = n_valid; f0 = n_ferr;
    repeat (480) drive_tick(1'b0);
    check("break_no_ferr", n_ferr - f0, 0);
    check("break_no_valid", n_valid - v0, 0);
    check("break_busy", rx_busy, 1);
    check("break_data_kept", rx_data, 8'hC3);
    repeat (32) drive_tick(1'b1);
    check("break_exit_busy", rx_busy, 0);
    send_frame(8'h81, 1'b1, 1'b0, 1'b0);
    check("after_break_valid", n_valid - v0, 1);
    check("after_break_data", rx_data, 8'h81);
    check("after_break_ferr", n_ferr - f0, 0);

    // False start: 4 low ticks, then high.
    v0 = n_valid; f0 = n_ferr;
    repeat (4) drive_tick(1'b0);
    check("false_start_busy_rise", rx_busy, 1);
    repeat (12) drive_tick(1'b1);
    check("false_start_busy_hold", rx_busy, 1);
    repeat (4) drive_tick(1'b1);
    check("false_start_busy_drop", rx_busy, 0);
    repeat (16) drive_tick(1'b1);
    check("false_start_valid", n_valid - v0, 0);
    check("false_start_ferr", n_ferr - f0, 0);

    // Reset in the middle of the data bits of 0x7E.
    drive_tick(1'b0);
    for (int s = 0; s < 3; s++) repeat (16) drive_tick(s == 0 ? 1'b0 : 1'b1);
    check("midframe_busy", rx_busy, 1);
    rxd   = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk50);
    check("midreset_rx_data", rx_data, 0);
    check("midreset_rx_valid", rx_valid, 0);
    check("midreset_rx_frame_err", rx_frame_err, 0);
    check("midreset_rx_busy", rx_busy, 0);
    rst_n = 1'b1;
    @(posedge tick16);
    repeat (16) drive_tick(1'b1);
    v0 = n_valid; f0 = n_ferr;
    send_frame(8'h7E, 1'b1, 1'b0, 1'b0);
    check("post_reset_valid", n_valid - v0, 1);
    check("post_reset_data", rx_data, 8'h7E);
    check("post_reset_ferr", n_ferr - f0, 0);

`ifdef UART_RX_PARITY_EN
    v0 = n_valid; f0 = n_ferr; p0 = n_perr;
    repeat (16) drive_tick(1'b1);
    send_frame(8'h01, 1'b1, 1'b0, 1'b1);
    check("parity_err_pulse", n_perr - p0, 1);
    check("parity_no_valid", n_valid - v0, 0);
    check("parity_data_kept", rx_data, 8'h7E);
    check("parity_no_ferr", n_ferr - f0, 0);
`else
    p0 = n_perr;
    repeat (16) drive_tick(1'b1);
    check("no_parity_err", n_perr - p0, 0);
`endif

    repeat (4) @(negedge clk50);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
